// File: rtl/i2c_seq_pkg.sv
// rtl/i2c_seq_pkg.sv - shared types and constants for the I2C command sequencer
package i2c_seq_pkg;

  localparam logic OP_WR = 1'b0;
  localparam logic OP_RD = 1'b1;

  // Width of the stored retry count; MAX_RETRY must fit in it.
  localparam int RETRY_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    GAP,
    RESP
  } state_t;

  typedef struct packed {
    logic       op;
    logic [6:0] addr;
    logic [7:0] data;
  } cmd_t;

  typedef struct packed {
    logic               op;
    logic [6:0]         addr;
    logic [7:0]         rdata;
    logic               ack_err;
    logic               timeout;
    logic [RETRY_W-1:0] retries;
  } rsp_t;

endpackage

// File: rtl/i2c_cmd_fifo.sv
// rtl/i2c_cmd_fifo.sv - command FIFO; full blocks pushes even when a pop is in the same cycle
module i2c_cmd_fifo
  import i2c_seq_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  cmd_t          wr_data,
  input  logic          pop,
  output cmd_t          rd_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// rtl/i2c_cmd_sequencer.sv - queues host I2C commands, issues them to i2c_top one at a time
module i2c_cmd_sequencer
  import i2c_seq_pkg::*;
#(
  parameter  int DEPTH       = 4,
  parameter  int NEWD_HOLD   = 5,
  parameter  int MAX_RETRY   = 2,
  parameter  int TIMEOUT_CYC = 4096,
  localparam int RW          = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1,
  localparam int LW          = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_op,
  input  logic [6:0]    cmd_addr,
  input  logic [7:0]    cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_op,
  output logic [6:0]    rsp_addr,
  output logic [7:0]    rsp_rdata,
  output logic          rsp_ack_err,
  output logic          rsp_timeout,
  output logic [RW-1:0] rsp_retries,
  output logic [LW-1:0] fifo_level,
  output logic          i2c_newd,
  output logic          i2c_op,
  output logic [6:0]    i2c_addr,
  output logic [7:0]    i2c_din,
  input  logic [7:0]    i2c_dout,
  input  logic          i2c_busy,
  input  logic          i2c_ack_err,
  input  logic          i2c_done
);

  localparam int HW = $clog2(NEWD_HOLD + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t        state;
  cmd_t          cmd_in;
  cmd_t          head;
  cmd_t          cmd_q;
  rsp_t          rsp_q;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] to_cnt;
  logic          done_q;
  logic          done_edge;
  logic          full;
  logic          empty;
  logic          pop;

  assign cmd_in    = '{op: cmd_op, addr: cmd_addr, data: cmd_wdata};
  assign done_edge = i2c_done & ~done_q;
  assign pop       = (state == IDLE) & ~empty & ~i2c_busy;
  assign cmd_ready = ~full;

  i2c_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (cmd_valid),
    .wr_data (cmd_in),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  // The command register drives i2c_top directly, so the payload is stable for the whole transfer.
  assign i2c_op      = cmd_q.op;
  assign i2c_addr    = cmd_q.addr;
  assign i2c_din     = cmd_q.data;
  assign rsp_op      = rsp_q.op;
  assign rsp_addr    = rsp_q.addr;
  assign rsp_rdata   = rsp_q.rdata;
  assign rsp_ack_err = rsp_q.ack_err;
  assign rsp_timeout = rsp_q.timeout;
  assign rsp_retries = rsp_q.retries[RW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd_q     <= '0;
      rsp_q     <= '0;
      rsp_valid <= 1'b0;
      i2c_newd  <= 1'b0;
      hold_cnt  <= '0;
      to_cnt    <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= i2c_done;
      case (state)
        IDLE: begin
          if (pop) begin
            cmd_q         <= head;
            rsp_q.retries <= '0;
            hold_cnt      <= '0;
            i2c_newd      <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (hold_cnt == HW'(NEWD_HOLD - 1)) begin
            i2c_newd <= 1'b0;
            to_cnt   <= '0;
            state    <= WAIT_DONE;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        WAIT_DONE: begin
          // A done edge takes priority over a timeout expiring in the same cycle.
          if (done_edge) begin
            if (i2c_ack_err && (rsp_q.retries < RETRY_W'(MAX_RETRY))) begin
              rsp_q.retries <= rsp_q.retries + RETRY_W'(1);
              state         <= GAP;
            end else begin
              rsp_q.op      <= cmd_q.op;
              rsp_q.addr    <= cmd_q.addr;
              rsp_q.rdata   <= (cmd_q.op == OP_RD) ? i2c_dout : 8'h00;
              rsp_q.ack_err <= i2c_ack_err;
              rsp_q.timeout <= 1'b0;
              rsp_valid     <= 1'b1;
              state         <= RESP;
            end
          end else if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
            rsp_q.op      <= cmd_q.op;
            rsp_q.addr    <= cmd_q.addr;
            rsp_q.rdata   <= 8'h00;
            rsp_q.ack_err <= 1'b0;
            rsp_q.timeout <= 1'b1;
            rsp_valid     <= 1'b1;
            state         <= RESP;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        GAP: begin
          if (!i2c_busy) begin
            hold_cnt <= '0;
            i2c_newd <= 1'b1;
            state    <= ISSUE;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// tb/tb_i2c_cmd_sequencer.sv - scoreboard bench for i2c_cmd_sequencer with a behavioural i2c_top slave
module tb_i2c_cmd_sequencer;

  localparam int DEPTH       = 4;
  localparam int NEWD_HOLD   = 5;
  localparam int MAX_RETRY   = 2;
  localparam int TIMEOUT_CYC = 64;
  localparam logic [6:0] HANG_ADDR  = 7'h50;
  localparam logic [6:0] NACK_ADDR  = 7'h51;
  localparam logic [6:0] LEVEL_ADDR = 7'h02;

  typedef struct {
    logic       op;
    logic [6:0] addr;
    logic [7:0] data;
    logic [7:0] rdata;
    logic       ack_err;
    logic       timeout;
    int         retries;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid, cmd_ready, cmd_op;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_ready, rsp_op, rsp_ack_err, rsp_timeout;
  logic [6:0] rsp_addr;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_retries;
  logic [2:0] fifo_level;
  logic       i2c_newd, i2c_op, i2c_busy, i2c_ack_err, i2c_done;
  logic [6:0] i2c_addr;
  logic [7:0] i2c_din, i2c_dout;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  int   rise_cyc = 0;
  int   fall_cyc = -1000;
  int   bursts = 0;
  int   peak = 0;
  bit   pushes_done;

  i2c_cmd_sequencer #(
    .DEPTH(DEPTH), .NEWD_HOLD(NEWD_HOLD), .MAX_RETRY(MAX_RETRY), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_addr(rsp_addr),
    .rsp_rdata(rsp_rdata), .rsp_ack_err(rsp_ack_err), .rsp_timeout(rsp_timeout),
    .rsp_retries(rsp_retries), .fifo_level(fifo_level),
    .i2c_newd(i2c_newd), .i2c_op(i2c_op), .i2c_addr(i2c_addr), .i2c_din(i2c_din),
    .i2c_dout(i2c_dout), .i2c_busy(i2c_busy), .i2c_ack_err(i2c_ack_err), .i2c_done(i2c_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] slave_data(logic [6:0] a);
    return (a == LEVEL_ADDR) ? 8'hA5 : ({1'b0, a} ^ 8'h3C);
  endfunction

  function automatic exp_t make_exp(logic op, logic [6:0] addr, logic [7:0] data);
    exp_t e;
    e.op      = op;
    e.addr    = addr;
    e.data    = data;
    e.timeout = (addr == HANG_ADDR);
    e.ack_err = (addr == NACK_ADDR);
    e.retries = e.ack_err ? MAX_RETRY : 0;
    e.rdata   = (op && !e.timeout) ? slave_data(addr) : 8'h00;
    return e;
  endfunction

  task automatic push(logic op, logic [6:0] addr, logic [7:0] data);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = data;
    @(negedge clk);
    while (!cmd_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", cmd_ready, 1);
    if (cmd_ready) begin
      @(posedge clk);
      exp_q.push_back(make_exp(op, addr, data));
      #1;
      accept_cyc = cyc;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  // Behavioural i2c_top: busy from newd until a few cycles after done; HANG_ADDR never completes.
  initial begin
    int  hold = 0, svc = 0, tail = 0;
    bit  newd_prev = 0, valid_prev = 0, level_mode = 0, hang = 0;
    i2c_busy = 0; i2c_done = 0; i2c_ack_err = 0; i2c_dout = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        i2c_busy = 0; i2c_done = 0; i2c_ack_err = 0;
        svc = 0; tail = 0; hold = 0; newd_prev = 0; valid_prev = 0; bursts = 0;
        continue;
      end
      if (i2c_done && !level_mode) i2c_done = 0;
      if (i2c_newd && !newd_prev) begin
        check("busy_at_newd", i2c_busy, 0);
        bursts++;
        rise_cyc = cyc;
        hold = 1;
        i2c_busy = 1; i2c_done = 0; i2c_ack_err = 0;
      end else if (i2c_newd) begin
        hold++;
      end
      if (!i2c_newd && newd_prev) begin
        check("newd_len", hold, NEWD_HOLD);
        fall_cyc   = cyc;
        hang       = (i2c_addr == HANG_ADDR);
        level_mode = (i2c_addr == LEVEL_ADDR);
        svc        = hang ? 12 : 5;
      end else if (svc > 0) begin
        svc--;
        if (svc == 0) begin
          if (hang) begin
            i2c_busy = 0;
          end else begin
            if (exp_q.size() > 0) begin
              check("i2c_addr", i2c_addr, exp_q[0].addr);
              check("i2c_op", i2c_op, exp_q[0].op);
              check("i2c_din", i2c_din, exp_q[0].op ? i2c_din : exp_q[0].data);
            end else begin
              check("inflight_expected", 0, 1);
            end
            i2c_done    = 1;
            i2c_ack_err = (i2c_addr == NACK_ADDR);
            i2c_dout    = slave_data(i2c_addr);
            tail        = 3;
          end
        end
      end else if (tail > 0) begin
        tail--;
        if (tail == 0) i2c_busy = 0;
      end
      if (rsp_valid && !valid_prev && exp_q.size() > 0 && exp_q[0].timeout)
        check("timeout_lat", cyc - fall_cyc, TIMEOUT_CYC);
      newd_prev  = i2c_newd;
      valid_prev = rsp_valid;
    end
  end

  // Response scoreboard and hold-stability monitor.
  initial begin
    exp_t        e;
    logic [19:0] snap, snap_prev;
    bit          hold_prev = 0;
    int          base = 0;
    snap_prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_prev = 0;
        base = 0;
        continue;
      end
      if (int'(fifo_level) > peak) peak = fifo_level;
      snap = {rsp_op, rsp_addr, rsp_rdata, rsp_ack_err, rsp_timeout, rsp_retries};
      if (hold_prev && rsp_valid) check("rsp_stable", snap, snap_prev);
      hold_prev = rsp_valid && !rsp_ready;
      snap_prev = snap;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_op", rsp_op, e.op);
          check("rsp_addr", rsp_addr, e.addr);
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_ack_err", rsp_ack_err, e.ack_err);
          check("rsp_timeout", rsp_timeout, e.timeout);
          check("rsp_retries", rsp_retries, e.retries);
          check("bursts", bursts - base, e.retries + 1);
          base = bursts;
        end
      end
    end
  end

  initial begin
    int n;
    cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_newd", i2c_newd, 0);
    check("rst_level", fifo_level, 0);
    check("rst_rsp_addr", rsp_addr, 0);
    rst = 0;
    @(posedge clk);
    #1;

    push(0, 7'h03, 8'h05);
    wait_drain(300);
    check("newd_latency", rise_cyc - accept_cyc, 1);

    push(1, LEVEL_ADDR, 8'h00);
    push(1, 7'h33, 8'h00);
    wait_drain(300);

    push(0, NACK_ADDR, 8'h77);
    wait_drain(400);

    push(0, HANG_ADDR, 8'h01);
    push(0, 7'h11, 8'h22);
    wait_drain(600);

    rsp_ready   = 0;
    pushes_done = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) push(logic'(i % 2), 7'h20 + 7'(i), 8'h40 + 8'(i));
        pushes_done = 1;
      end
    join_none
    repeat (40) @(posedge clk);
    #1;
    check("full_level", fifo_level, 4);
    check("full_cmd_ready", cmd_ready, 0);
    check("held_rsp_valid", rsp_valid, 1);
    check("held_rsp_addr", rsp_addr, 7'h20);
    check("peak_level", peak, 4);
    rsp_ready = 1;
    n = 0;
    while (!pushes_done && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("pushes_done", pushes_done, 1);
    wait_drain(800);

    push(0, HANG_ADDR, 8'h00);
    n = 0;
    while (fall_cyc < accept_cyc && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reached_wait_done", fall_cyc >= accept_cyc, 1);
    push(0, 7'h12, 8'h01);
    push(0, 7'h13, 8'h02);
    check("pre_rst_level", fifo_level, 2);
    @(posedge clk);
    #3;
    rst = 1;
    #1;
    check("arst_newd", i2c_newd, 0);
    check("arst_rsp_valid", rsp_valid, 0);
    check("arst_level", fifo_level, 0);
    check("arst_cmd_ready", cmd_ready, 1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    repeat (150) @(posedge clk);
    #1;
    check("post_rst_rsp_valid", rsp_valid, 0);
    check("post_rst_level", fifo_level, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/i2c_cmd_sequencer.md
Name: i2c_cmd_sequencer

Overview:
- Upstream command stage for i2c_top.
- Buffers host I2C transactions in a small FIFO and issues them one at a time on i2c_top's newd/op/addr/din interface.
- Watches done/ack_err, retries NACKed transfers and guards against hangs with a timeout.
- Returns one response per command (read data plus status) over a valid/ready port.

Parameters:
- DEPTH, 4: command FIFO entries; power of two, ≥2.
- NEWD_HOLD, 5: cycles i2c_newd is held high per issue (≥1).
- MAX_RETRY, 2: re-issues after ack_err before reporting failure (0 = no retry).
- TIMEOUT_CYC, 4096: cycles allowed in WAIT_DONE before abort.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  FIFO can accept.
- cmd_op  in  1  0 = write, 1 = read.
- cmd_addr  in  7  slave address.
- cmd_wdata  in  8  write data (ignored for reads).
- rsp_valid  out  1  response available.
- rsp_ready  in  1  host takes response.
- rsp_op  out  1  op of completed command.
- rsp_addr  out  7  address of completed command.
- rsp_rdata  out  8  read data (0 for writes and on timeout).
- rsp_ack_err  out  1  final attempt NACKed.
- rsp_timeout  out  1  done never seen.
- rsp_retries  out  $clog2(MAX_RETRY+1)  retries used.
- fifo_level  out  $clog2(DEPTH+1)  commands queued.
- i2c_newd  out  1  to i2c_top newd.
- i2c_op  out  1  to i2c_top op.
- i2c_addr  out  7  to i2c_top addr.
- i2c_din  out  8  to i2c_top din.
- i2c_dout  in  8  from i2c_top dout.
- i2c_busy  in  1  from i2c_top busy.
- i2c_ack_err  in  1  from i2c_top ack_err.
- i2c_done  in  1  from i2c_top done.

Behaviour:
- Reset values: all outputs 0, except cmd_ready = 1 (FIFO empty). FIFO flushed, FSM in IDLE, counters cleared.
- Reset mid-transaction:
  - i2c_newd falls immediately (asynchronous).
  - The in-flight command and any pending response are discarded; no response is emitted.
- FIFO:
  - Push on cmd_valid & cmd_ready.
  - cmd_ready = !full, with no full-bypass: a simultaneous pop while full does not raise cmd_ready in that cycle.
  - Simultaneous push and pop when neither full nor empty leaves the level unchanged.
  - Pointers wrap modulo DEPTH.
- All i2c_* outputs and rsp_* outputs are registered.
- The done edge is detected as i2c_done & !done_q, where done_q is i2c_done registered; both level and pulse forms of done are handled.
- FSM states: IDLE, ISSUE, WAIT_DONE, GAP, RESP.
- IDLE: when FIFO non-empty and !i2c_busy, pop the head into the command register, drive i2c_op/addr/din from it, set i2c_newd = 1, clear the retry counter, go to ISSUE.
  - Latency: command accepted on edge E into an empty FIFO while idle → i2c_newd high from edge E+1.
- ISSUE:
  - i2c_newd held high for exactly NEWD_HOLD cycles, then cleared.
  - Go to WAIT_DONE with the timeout counter cleared.
  - op/addr/din stay stable from ISSUE until the FSM leaves WAIT_DONE.
- WAIT_DONE:
  - On a done edge with i2c_ack_err = 1 and retries < MAX_RETRY: increment retries, go to GAP.
  - On a done edge otherwise: capture rsp_rdata (= i2c_dout for reads, 0 for writes) and rsp_ack_err = i2c_ack_err; go to RESP.
  - On TIMEOUT_CYC cycles with no done edge: rsp_timeout = 1, rsp_rdata = 0, rsp_ack_err = 0; go to RESP.
  - A done edge and timeout expiry in the same cycle: the done edge wins.
- GAP: wait for !i2c_busy, then reassert i2c_newd and return to ISSUE (same command, same payload).
- RESP:
  - rsp_valid = 1; all rsp_* fields are stable while rsp_valid & !rsp_ready.
  - On rsp_ready: clear rsp_valid, go to IDLE.
  - The next command is not issued before the response is taken (strict in-order, one outstanding).
- fifo_level counts queued entries only, not the in-flight command.

Decomposition:
- Package i2c_seq_pkg:
  - state enum: IDLE, ISSUE, WAIT_DONE, GAP, RESP.
  - cmd_t struct: op, addr[6:0], data[7:0].
  - rsp_t struct: op, addr, rdata, ack_err, timeout, retries.
  - OP_WR = 0, OP_RD = 1 constants.
- Sub-module i2c_cmd_fifo: parameterised DEPTH synchronous FIFO of cmd_t with full/empty/level and async reset.
- The FSM, counters and response register stay in i2c_cmd_sequencer.

Test Plan:
- Single write addr=3 data=5, slave ACKs → i2c_newd high exactly 5 cycles starting the cycle after acceptance; after done, one response: op=0, addr=3, rdata=0, ack_err=0, timeout=0, retries=0.
- Read addr=2, slave returns 0xA5 → rsp_rdata=0xA5, ack_err=0; i2c_addr=2 and i2c_op=1 stable through WAIT_DONE.
- Write with slave NACK on every attempt, MAX_RETRY=2 → exactly 3 newd bursts, each issued only after busy deasserts; response ack_err=1, retries=2.
- i2c_done held low, TIMEOUT_CYC=64 → response timeout=1, rdata=0 exactly 64 cycles after entering WAIT_DONE; the next queued command then issues.
- Push 5 commands back-to-back with rsp_ready=0 → cmd_ready falls after the FIFO fills; fifo_level peaks at 4; responses are held until rsp_ready, then drain in order with matching addr values.
- Assert rst during WAIT_DONE → i2c_newd=0 and rsp_valid=0 immediately, fifo_level=0, cmd_ready=1; no stale response after reset release.
